// File: rtl/sp_pkg.sv
// Shared definitions for the stack-pointer push/pop paths: FSM states and
// default stack geometry.
package sp_pkg;

    localparam int          W_DEFAULT         = 16;
    localparam logic [15:0] STACK_TOP_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } sp_state_e;

endpackage

// File: rtl/sp_pop_ctrl_if.sv
// Stack-memory read port: one-cycle read strobe with held address, answered
// by a read-valid pulse carrying the data.
interface sp_pop_ctrl_if
    import sp_pkg::*;
#(
    parameter int W = W_DEFAULT
);

    logic         mem_rd_en;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_rd_data;
    logic         mem_rd_valid;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        input  mem_rd_valid
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        output mem_rd_valid
    );

endinterface

// File: rtl/sp_adder.sv
// Combinational W-bit +1 incrementer for the pop path; mirror of the push-side
// decrementer. Wraps modulo 2^W.
module sp_adder
    import sp_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = a + W'(1);

endmodule

// File: rtl/sp_pop_ctrl.sv
// Stack-pop / return controller: increments SP, reads the return address from
// stack memory, then presents it to the PC logic and writes SP back.
module sp_pop_ctrl
    import sp_pkg::*;
#(
    parameter int           W         = W_DEFAULT,
    parameter logic [W-1:0] STACK_TOP = W'(STACK_TOP_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ret_req,
    input  logic [W-1:0]  sp_in,
    sp_pop_ctrl_if.master mem,
    output logic [W-1:0]  sp_out,
    output logic          sp_we,
    output logic [W-1:0]  ret_addr,
    output logic          ret_valid,
    output logic          busy,
    output logic          underflow
);

    sp_state_e    state_q, state_d;
    logic [W-1:0] sp_inc;
    logic [W-1:0] sp_inc_q, sp_inc_d;
    logic         mem_rd_en_q, mem_rd_en_d;
    logic [W-1:0] mem_addr_q, mem_addr_d;
    logic [W-1:0] sp_out_q, sp_out_d;
    logic         sp_we_q, sp_we_d;
    logic [W-1:0] ret_addr_q, ret_addr_d;
    logic         ret_valid_q, ret_valid_d;
    logic         busy_q, busy_d;
    logic         underflow_q, underflow_d;

    sp_adder #(.W(W)) u_sp_adder (
        .a (sp_in),
        .y (sp_inc)
    );

    // Outputs are registered, so each one is computed from the state being
    // entered rather than the state being left.
    always_comb begin
        state_d     = state_q;
        sp_inc_d    = sp_inc_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        sp_out_d    = sp_out_q;
        sp_we_d     = 1'b0;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = 1'b0;
        underflow_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ret_req) begin
                    if (sp_in == STACK_TOP) begin
                        state_d     = ERR;
                        underflow_d = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        sp_inc_d    = sp_inc;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = sp_inc;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem.mem_rd_valid) begin
                    state_d     = DONE;
                    ret_addr_d  = mem.mem_rd_data;
                    sp_out_d    = sp_inc_q;
                    ret_valid_d = 1'b1;
                    sp_we_d     = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sp_inc_q    <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            sp_out_q    <= STACK_TOP;
            sp_we_q     <= 1'b0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_inc_q    <= sp_inc_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            sp_out_q    <= sp_out_d;
            sp_we_q     <= sp_we_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
            busy_q      <= busy_d;
            underflow_q <= underflow_d;
        end
    end

    assign mem.mem_rd_en = mem_rd_en_q;
    assign mem.mem_addr  = mem_addr_q;
    assign sp_out        = sp_out_q;
    assign sp_we         = sp_we_q;
    assign ret_addr      = ret_addr_q;
    assign ret_valid     = ret_valid_q;
    assign busy          = busy_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_sp_pop_ctrl.sv
// Directed bench for sp_pop_ctrl: reset, normal and slow pops, underflow,
// busy rejection, back-to-back pops and reset abort.
module tb_sp_pop_ctrl;

    logic        clk;
    logic        rst;
    logic        ret_req;
    logic [15:0] sp_in;
    logic [15:0] sp_out;
    logic        sp_we;
    logic [15:0] ret_addr;
    logic        ret_valid;
    logic        busy;
    logic        underflow;

    int n_tests;
    int n_fail;
    int cyc;

    sp_pop_ctrl_if #(.W(16)) mem_if ();

    sp_pop_ctrl #(.W(16), .STACK_TOP(16'hFFFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .ret_req   (ret_req),
        .sp_in     (sp_in),
        .mem       (mem_if),
        .sp_out    (sp_out),
        .sp_we     (sp_we),
        .ret_addr  (ret_addr),
        .ret_valid (ret_valid),
        .busy      (busy),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rd_en, input logic [15:0] addr,
                           input logic [15:0] spo, input logic we, input logic [15:0] ra,
                           input logic rv, input logic bz, input logic uf);
        check({tag, ".rd_en"},     {15'd0, mem_if.mem_rd_en}, {15'd0, rd_en});
        check({tag, ".addr"},      mem_if.mem_addr,           addr);
        check({tag, ".sp_out"},    sp_out,                    spo);
        check({tag, ".sp_we"},     {15'd0, sp_we},            {15'd0, we});
        check({tag, ".ret_addr"},  ret_addr,                  ra);
        check({tag, ".ret_valid"}, {15'd0, ret_valid},        {15'd0, rv});
        check({tag, ".busy"},      {15'd0, busy},             {15'd0, bz});
        check({tag, ".underflow"}, {15'd0, underflow},        {15'd0, uf});
    endtask

    initial begin
        int rv_cnt;
        int we_cnt;
        int rd_cnt;
        int t_first;
        int t_second;

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst     = 1'b1;
        ret_req = 1'b0;
        sp_in   = 16'h0000;
        mem_if.mem_rd_valid = 1'b0;
        mem_if.mem_rd_data  = 16'h0000;

        tick();
        tick();
        chk_all("reset", 1'b0, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Basic pop, single-cycle memory
        sp_in   = 16'hFFFD;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk_all("basic.n1", 1'b1, 16'hFFFE, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("basic.n2", 1'b0, 16'hFFFE, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        mem_if.mem_rd_valid = 1'b1;
        mem_if.mem_rd_data  = 16'h1015;
        tick();
        mem_if.mem_rd_valid = 1'b0;
        chk_all("basic.n3", 1'b0, 16'hFFFE, 16'hFFFE, 1'b1, 16'h1015, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("basic.idle", 1'b0, 16'hFFFE, 16'hFFFE, 1'b0, 16'h1015, 1'b0, 1'b0, 1'b0);

        // Slow memory: valid five cycles after the read strobe
        sp_in   = 16'h00F0;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk_all("slow.n1", 1'b1, 16'h00F1, 16'hFFFE, 1'b0, 16'h1015, 1'b0, 1'b1, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            tick();
            chk_all("slow.wait", 1'b0, 16'h00F1, 16'hFFFE, 1'b0, 16'h1015, 1'b0, 1'b1, 1'b0);
        end
        mem_if.mem_rd_valid = 1'b1;
        mem_if.mem_rd_data  = 16'hABA2;
        tick();
        mem_if.mem_rd_valid = 1'b0;
        chk_all("slow.n7", 1'b0, 16'h00F1, 16'h00F1, 1'b1, 16'hABA2, 1'b1, 1'b1, 1'b0);
        tick();

        // Underflow on empty stack
        sp_in   = 16'hFFFF;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk_all("uflow.n1", 1'b0, 16'h00F1, 16'h00F1, 1'b0, 16'hABA2, 1'b0, 1'b1, 1'b1);
        tick();
        chk_all("uflow.n2", 1'b0, 16'h00F1, 16'h00F1, 1'b0, 16'hABA2, 1'b0, 1'b0, 1'b0);
        tick();
        check("uflow.no_rd", {15'd0, mem_if.mem_rd_en}, 16'h0000);

        // Busy rejection: second request during WAIT is dropped
        sp_in   = 16'h1000;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk_all("busy.n1", 1'b1, 16'h1001, 16'h00F1, 1'b0, 16'hABA2, 1'b0, 1'b1, 1'b0);
        tick();
        sp_in   = 16'h2000;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk_all("busy.wait", 1'b0, 16'h1001, 16'h00F1, 1'b0, 16'hABA2, 1'b0, 1'b1, 1'b0);
        mem_if.mem_rd_valid = 1'b1;
        mem_if.mem_rd_data  = 16'h5A5A;
        tick();
        mem_if.mem_rd_valid = 1'b0;
        chk_all("busy.done", 1'b0, 16'h1001, 16'h1001, 1'b1, 16'h5A5A, 1'b1, 1'b1, 1'b0);
        rv_cnt = 0;
        we_cnt = 0;
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            // stray read-valid while idle must be ignored
            mem_if.mem_rd_valid = (i == 2);
            mem_if.mem_rd_data  = 16'hBEEF;
            tick();
            rv_cnt += int'(ret_valid);
            we_cnt += int'(sp_we);
            rd_cnt += int'(mem_if.mem_rd_en);
        end
        mem_if.mem_rd_valid = 1'b0;
        check("busy.extra_ret_valid", 16'(rv_cnt), 16'd0);
        check("busy.extra_sp_we",     16'(we_cnt), 16'd0);
        check("busy.extra_rd_en",     16'(rd_cnt), 16'd0);
        check("busy.ret_addr_hold",   ret_addr,    16'h5A5A);

        // Back-to-back pops
        sp_in   = 16'hFFFC;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        check("b2b.addr1", mem_if.mem_addr, 16'hFFFD);
        check("b2b.rd1",   {15'd0, mem_if.mem_rd_en}, 16'h0001);
        tick();
        mem_if.mem_rd_valid = 1'b1;
        mem_if.mem_rd_data  = 16'h0111;
        tick();
        mem_if.mem_rd_valid = 1'b0;
        t_first = cyc;
        chk_all("b2b.done1", 1'b0, 16'hFFFD, 16'hFFFD, 1'b1, 16'h0111, 1'b1, 1'b1, 1'b0);
        tick();
        check("b2b.idle", {15'd0, busy}, 16'h0000);
        sp_in   = 16'hFFFD;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        check("b2b.addr2", mem_if.mem_addr, 16'hFFFE);
        check("b2b.rd2",   {15'd0, mem_if.mem_rd_en}, 16'h0001);
        tick();
        mem_if.mem_rd_valid = 1'b1;
        mem_if.mem_rd_data  = 16'h0222;
        tick();
        mem_if.mem_rd_valid = 1'b0;
        t_second = cyc;
        chk_all("b2b.done2", 1'b0, 16'hFFFE, 16'hFFFE, 1'b1, 16'h0222, 1'b1, 1'b1, 1'b0);
        check("b2b.spacing", 16'(t_second - t_first), 16'd4);
        tick();

        // Reset mid-WAIT aborts the pop
        sp_in   = 16'h0300;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        check("rst.issue_addr", mem_if.mem_addr, 16'h0301);
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_all("rst.mid", 1'b0, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        mem_if.mem_rd_valid = 1'b1;
        mem_if.mem_rd_data  = 16'hDEAD;
        tick();
        mem_if.mem_rd_valid = 1'b0;
        chk_all("rst.late_valid", 1'b0, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("rst.after", 1'b0, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_pop_ctrl.md
Name: sp_pop_ctrl

Overview:
- Stack-pop / return controller. It is the read-side counterpart of the stack-pointer decrement path used on jump/call push.
- On a return request it increments SP, then reads the return address from stack memory through a request/valid handshake.
- It presents the popped address to the PC logic and writes the updated SP back to the SP register.
- It sits between the control unit, the SP register and the data-memory read port.

Parameters:
- W, 16, width of SP, memory address and memory data.
- STACK_TOP, 16'hFFFF, SP value when the stack is empty. Stack grows downward; SP points to the next free slot.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- ret_req  input  1  return/pop request pulse from control unit; sampled only in IDLE.
- sp_in  input  W  current SP register value.
- mem_rd_en  output  1  one-cycle read strobe to stack memory.
- mem_addr  output  W  read address; valid while mem_rd_en=1 and held until mem_rd_valid.
- mem_rd_data  input  W  read data from stack memory.
- mem_rd_valid  input  1  read data valid; earliest one cycle after mem_rd_en.
- sp_out  output  W  new SP value (sp_in+1).
- sp_we  output  1  one-cycle write enable for the SP register.
- ret_addr  output  W  popped return address.
- ret_valid  output  1  one-cycle pulse; ret_addr is valid.
- busy  output  1  high in every state except IDLE.
- underflow  output  1  one-cycle pulse when a pop is requested on an empty stack.

Behaviour:
- Reset:
  - All outputs are registered.
  - On rst=1 at a clock edge: state=IDLE, mem_rd_en=0, mem_addr=0, sp_out=STACK_TOP, sp_we=0, ret_addr=0, ret_valid=0, busy=0, underflow=0.
  - Reset has priority over everything. Reset mid-operation aborts the pop: no sp_we, no ret_valid, and any late mem_rd_valid is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - ret_req=1 and sp_in==STACK_TOP: go to ERR.
  - ret_req=1 otherwise: latch sp_inc=sp_in+1 (mod 2^W), go to ISSUE.
  - ret_req=0: stay in IDLE.
- ISSUE: mem_rd_en=1 and mem_addr=sp_inc for exactly one cycle; go to WAIT.
- WAIT:
  - mem_addr is held.
  - On mem_rd_valid=1: latch ret_addr=mem_rd_data, sp_out=sp_inc; go to DONE.
  - There is no timeout; the block waits indefinitely.
- DONE: ret_valid=1 and sp_we=1 for exactly one cycle; return to IDLE.
- ERR: underflow=1 for one cycle. No memory access, sp_we stays 0, SP is unchanged. Return to IDLE.
- Latency: ret_req sampled at edge n gives mem_rd_en high in cycle n+1. With single-cycle memory, ret_valid/sp_we are high in cycle n+3.
- Back-to-back pops: a new ret_req is accepted in the IDLE cycle after DONE. The control unit must present the updated sp_in by then; the SP register is written on the DONE edge.
- ret_req while busy=1 is ignored, not queued.
- mem_rd_valid outside WAIT is ignored.
- ret_addr and sp_out hold their last values between pops.
- Arithmetic: unsigned W-bit; sp_in+1 wraps modulo 2^W. With STACK_TOP=2^W-1, wrap is unreachable because ERR catches the empty case.

Decomposition:
- Shared package sp_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE, ERR).
  - STACK_TOP_DEFAULT and W_DEFAULT constants, shared with the push-side decrementer.
- One natural sub-module: sp_adder. It is a combinational W-bit +1 incrementer, the mirror of the push-side subtractor, and is instantiated once to produce sp_inc.

Test Plan:
- Reset: assert rst for 2 cycles mid-WAIT -> all outputs at reset values, state IDLE, later mem_rd_valid ignored, no ret_valid.
- Basic pop: sp_in=16'hFFFD, ret_req pulse, memory returns 16'h1015 one cycle after rd_en:
  - mem_rd_en in cycle n+1 with mem_addr=16'hFFFE;
  - ret_valid=1, ret_addr=16'h1015, sp_we=1, sp_out=16'hFFFE in cycle n+3.
- Slow memory: sp_in=16'h00F0, mem_rd_valid delayed 5 cycles, data 16'hABA2:
  - mem_addr=16'h00F1 held and busy=1 throughout;
  - ret_valid in cycle n+7, ret_addr=16'hABA2.
- Underflow: sp_in=16'hFFFF, ret_req -> underflow=1 in cycle n+1, mem_rd_en never asserted, sp_we=0.
- Busy rejection: second ret_req during WAIT -> exactly one ret_valid and one sp_we pulse.
- Back-to-back: two pops from sp_in=16'hFFFC (sp_in updated after first sp_we):
  - addresses 16'hFFFD then 16'hFFFE;
  - sp_out 16'hFFFD then 16'hFFFE;
  - two ret_valid pulses, 4 cycles apart.
